// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment capture path: the active-low hex
// pattern table (same table the encoder drives) and the dwell FSM states.
package sevseg_pkg;

  localparam int SEG_W = 7;

  // Active-low patterns, bit0=a .. bit6=g, indexed by hex digit 0..F.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Dwell tracker: no strobe, waiting for stability, already accepted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sevseg_inv_dec.sv
// Inverse seven-segment decoder: maps an active-low segment pattern back to
// its hex nibble. Patterns outside the table report o_valid=0.
module sevseg_inv_dec
  import sevseg_pkg::*;
(
  input  logic [SEG_W-1:0] i_pat,
  output logic [3:0]       o_nibble,
  output logic             o_valid
);

  // Table search; at most one entry can match since all patterns are distinct.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_nibble = 4'h0;
    o_valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_pat == SEG_HEX[i]) begin
        o_nibble = 4'(i);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevseg_capture.sv
// Receive side of the multiplexed seven-segment bus. Registers the bus once,
// waits for each digit dwell to be stable, decodes the accepted pattern into
// a shadow nibble and publishes the whole value once every digit has been seen.
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  flush,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic [DIGITS-1:0]     err_digit
);

  localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  // Registered bus sample and the sample before it
  logic [SEG_W-1:0]    r_seg_q;
  logic [DIGITS-1:0]   r_dig_q;
  logic [SEG_W-1:0]    r_seg_prev;
  logic [DIGITS-1:0]   r_dig_prev;

  // Dwell tracker
  cap_state_e          r_state;
  cap_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_cur;
  logic                w_eval;
  logic                w_accept;

  // Frame assembly
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] w_shadow_nxt;
  logic [DIGITS-1:0]   r_seen;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic [DIGITS-1:0]   r_bad;
  logic [DIGITS-1:0]   w_bad_nxt;
  logic                w_complete;

  // Published outputs
  logic [4*DIGITS-1:0] r_value;
  logic                r_value_valid;
  logic [DIGITS-1:0]   r_err;

  // Decode path
  logic [SEG_W-1:0]    w_pat;
  logic [3:0]          w_nibble;
  logic                w_dec_ok;
  logic                w_strobe_ok;
  logic                w_same;

  assign w_strobe_ok = $onehot(r_dig_q);
  assign w_same      = ({r_seg_q, r_dig_q} == {r_seg_prev, r_dig_prev});
  assign w_pat       = (ACTIVE_LOW != 0) ? r_seg_q : ~r_seg_q;
  assign w_complete  = &r_seen;

  sevseg_inv_dec u_dec (
    .i_pat    (w_pat),
    .o_nibble (w_nibble),
    .o_valid  (w_dec_ok)
  );

  // Single input register stage plus one-deep history for the stability compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_q    <= '0;
      r_dig_q    <= '0;
      r_seg_prev <= '0;
      r_dig_prev <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so r_seg_prev takes the old r_seg_q, not the value written a line above.
      r_seg_q    <= seg_in;
      r_dig_q    <= dig_sel;
      r_seg_prev <= r_seg_q;
      r_dig_prev <= r_dig_q;
    end
  end

  // Dwell state and stability count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next dwell state: count consecutive identical samples, accept once per dwell.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_cur   = '0;
    w_eval      = 1'b0;
    w_accept    = 1'b0;
    if (!w_strobe_ok) begin
      // Blanking: zero or multi-hot strobe is never accepted.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_eval    = 1'b1;
          w_cnt_cur = CNT_ONE;
        end
        SETTLE: begin
          w_eval    = 1'b1;
          w_cnt_cur = w_same ? (r_cnt + CNT_ONE) : CNT_ONE;
        end
        HELD: begin
          // An unchanged dwell has already been accepted; only a change restarts counting.
          if (!w_same) begin
            w_eval    = 1'b1;
            w_cnt_cur = CNT_ONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_eval) begin
        w_cnt_nxt = w_cnt_cur;
        if (w_cnt_cur >= STABLE_C) begin
          w_accept    = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
    end
  end

  // Frame assembly: a completed frame clears seen/bad, an accept in the same
  // cycle starts the next frame, and flush overrides both.
  always_comb begin
    w_seen_nxt   = w_complete ? '0 : r_seen;
    w_bad_nxt    = w_complete ? '0 : r_bad;
    w_shadow_nxt = r_shadow;
    if (w_accept) begin
      w_seen_nxt = w_seen_nxt | r_dig_q;
      w_bad_nxt  = w_dec_ok ? (w_bad_nxt & ~r_dig_q) : (w_bad_nxt | r_dig_q);
      for (int k = 0; k < DIGITS; k++) begin
        // Invalid patterns leave the prior shadow nibble in place.
        if (r_dig_q[k] && w_dec_ok) begin
          w_shadow_nxt[4*k +: 4] = w_nibble;
        end
      end
    end
    if (flush) begin
      w_seen_nxt = '0;
      w_bad_nxt  = '0;
    end
  end

  // Shadow, seen and bad registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow nibbles are reset because a bad pattern in the first frame publishes the prior shadow value, which must be a defined 0.
      r_shadow <= '0;
      r_seen   <= '0;
      r_bad    <= '0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_seen   <= w_seen_nxt;
      r_bad    <= w_bad_nxt;
    end
  end

  // Publish the frame one edge after its last accept; value/err hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_err         <= '0;
    end else begin
      r_value_valid <= w_complete;
      if (w_complete) begin
        r_value <= r_shadow;
        r_err   <= r_bad;
      end
    end
  end

  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign err_digit   = r_err;

endmodule

// File: tb/tb_sevseg_capture.sv
// Bench for sevseg_capture: directed dwell sequences and randomized dwells.
// Expected frames come from a dwell-level model and are queued; a monitor
// pops and compares on every value_valid pulse.
module tb_sevseg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        flush = 1'b0;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  err_digit;

  sevseg_capture #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .flush       (flush),
    .value       (value),
    .value_valid (value_valid),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  // Hex glyph table, active low, index = digit value.
  logic [6:0] tb_hex [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_cmp = 0;
  int n_bad = 0;

  frame_t     exp_q[$];
  frame_t     last_exp;
  logic [3:0] m_shadow [4];
  logic [3:0] m_seen;
  logic [3:0] m_bad;
  logic [6:0] prev_seg;
  logic [3:0] prev_dig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    int d = -1;
    for (int i = 0; i < 16; i++) if (tb_hex[i] == p) d = i;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_seen   = '0;
    m_bad    = '0;
    last_exp = '0;
    prev_seg = '0;
    prev_dig = '0;
    exp_q.delete();
  endtask

  // One accepted digit; flush_now means flush lands on the accept edge and wins.
  task automatic model_accept(input logic [6:0] seg, input logic [3:0] dig, input bit flush_now);
    int k = 0;
    int d;
    frame_t f;
    for (int i = 0; i < 4; i++) if (dig[i]) k = i;
    d = decode(seg);
    if (d >= 0) begin
      m_shadow[k] = 4'(d);
      m_bad[k]    = 1'b0;
    end else begin
      m_bad[k] = 1'b1;
    end
    m_seen[k] = 1'b1;
    if (flush_now) begin
      m_seen = '0;
      m_bad  = '0;
    end else if (m_seen == 4'hF) begin
      f.v = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
      f.e = m_bad;
      exp_q.push_back(f);
      last_exp = f;
      m_seen = '0;
      m_bad  = '0;
    end
  endtask

  // Hold {seg,dig} on the pins for len cycles; flush is high during cycle fl_idx (-1: never).
  // The model is updated before driving so the expectation is queued ahead of the pulse.
  task automatic dwell(input logic [6:0] seg, input logic [3:0] dig, input int len, input int fl_idx);
    bit acc = ($countones(dig) == 1) && (len >= STABLE);
    bit fl  = (fl_idx >= 0) && (fl_idx < len);
    if (acc) model_accept(seg, dig, fl);
    else if (fl) begin
      m_seen = '0;
      m_bad  = '0;
    end
    prev_seg = seg;
    prev_dig = dig;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      seg_in  = seg;
      dig_sel = dig;
      flush   = (c == fl_idx);
    end
  endtask

  // Monitor: every pulse must match the oldest expected frame.
  frame_t mon_f;
  always @(negedge clk) begin
    if (!rst && value_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got value %h err %b, expected no pulse", value, err_digit);
      end else begin
        mon_f = exp_q.pop_front();
        check("frame_value", 32'(value), 32'(mon_f.v));
        check("frame_err", 32'(err_digit), 32'(mon_f.e));
      end
    end
  end

  initial begin
    logic [6:0] seg;
    logic [3:0] dig;
    int r;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_err", 32'(err_digit), 32'h0);

    // Basic frame -> 4321
    dwell(7'h79, 4'b0001, 6, -1);
    dwell(7'h24, 4'b0010, 6, -1);
    dwell(7'h30, 4'b0100, 6, -1);
    dwell(7'h19, 4'b1000, 6, -1);

    // Glitch before the real digit0 pattern, long dwell accepted once -> ECD2, then 6547
    dwell(7'h06, 4'b1000, 6, -1);
    dwell(7'h46, 4'b0100, 6, -1);
    dwell(7'h21, 4'b0010, 6, -1);
    dwell(7'h79, 4'b0001, 2, -1);
    dwell(7'h24, 4'b0001, 20, -1);
    dwell(7'h19, 4'b0010, 6, -1);
    dwell(7'h12, 4'b0100, 6, -1);
    dwell(7'h02, 4'b1000, 6, -1);
    dwell(7'h78, 4'b0001, 6, -1);

    // Invalid pattern on digit2 keeps its prior nibble and flags err
    dwell(7'h40, 4'b0001, 6, -1);
    dwell(7'h40, 4'b0010, 6, -1);
    dwell(7'h7F, 4'b0100, 6, -1);
    dwell(7'h40, 4'b1000, 6, -1);

    // Blanking strobes mid-frame are ignored -> 3210
    dwell(7'h40, 4'b0001, 6, -1);
    dwell(7'h79, 4'b0010, 6, -1);
    dwell(7'h40, 4'b0011, 10, -1);
    dwell(7'h40, 4'b0000, 10, -1);
    dwell(7'h24, 4'b0100, 6, -1);
    dwell(7'h30, 4'b1000, 6, -1);

    // Flush during blanking discards a partial frame -> DCBA
    dwell(7'h40, 4'b0100, 6, -1);
    dwell(7'h79, 4'b1000, 6, -1);
    dwell(7'h00, 4'b0000, 3, 1);
    dwell(7'h08, 4'b0001, 6, -1);
    dwell(7'h03, 4'b0010, 6, -1);
    dwell(7'h46, 4'b0100, 6, -1);
    dwell(7'h21, 4'b1000, 6, -1);

    // Flush on the final accept edge wins, then a full frame -> 8765
    dwell(7'h40, 4'b0001, 6, -1);
    dwell(7'h40, 4'b0010, 6, -1);
    dwell(7'h40, 4'b0100, 6, -1);
    dwell(7'h40, 4'b1000, 6, STABLE);
    dwell(7'h12, 4'b0001, 6, -1);
    dwell(7'h02, 4'b0010, 6, -1);
    dwell(7'h78, 4'b0100, 6, -1);
    dwell(7'h00, 4'b1000, 6, -1);

    // Randomized dwells: valid, blank and multi-hot strobes of varied length
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) dig = 4'b0001 << $urandom_range(0, 3);
      else if (r < 85) dig = 4'b0000;
      else begin
        dig = 4'($urandom_range(0, 15));
        while ($countones(dig) < 2) dig = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 85) seg = tb_hex[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      if (seg == prev_seg && dig == prev_dig) seg = seg ^ 7'h7F;
      dwell(seg, dig, $urandom_range(1, 10), -1);
    end

    // Reset mid-frame: partial data discarded, outputs cleared
    dwell(7'h40, 4'b0001, 6, -1);
    dwell(7'h79, 4'b0010, 6, -1);
    @(negedge clk);
    seg_in  = '0;
    dig_sel = '0;
    flush   = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_valid", 32'(value_valid), 32'h0);
    check("midreset_err", 32'(err_digit), 32'h0);

    // Digits 2,3 only do not complete; a full new frame does -> 3210 with digit order shuffled
    dwell(7'h24, 4'b0100, 6, -1);
    dwell(7'h30, 4'b1000, 6, -1);
    dwell(7'h79, 4'b0010, 6, -1);
    dwell(7'h40, 4'b0001, 6, -1);

    // Drain and final hold checks
    dwell(7'h00, 4'b0000, 20, -1);
    flush = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("hold_value", 32'(value), 32'(last_exp.v));
    check("hold_err", 32'(err_digit), 32'(last_exp.e));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
